// File: rtl/seg_scan_driver.sv
// Two-digit 7-segment scan driver: time-multiplexes tens/ones patterns onto a
// shared segment bus, double-buffering new patterns until the next frame boundary.
module seg_scan_driver #(
    parameter int REFRESH_DIV        = 50000,
    parameter int BLANK_CYCLES       = 2,
    parameter int BLANK_LEADING_ZERO = 1,
    parameter int SEG_ACTIVE_LOW     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       load,
    input  logic [6:0] seg_tens_in,
    input  logic [6:0] seg_ones_in,
    output logic [6:0] seg_out,
    output logic [1:0] dig_sel,
    output logic       frame_start,
    output logic       update_ack
);

    localparam int               DIV_W      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       ZERO_GLYPH = 7'b1111110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TENS = 2'd1,
        ONES = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div, div_nxt;
    logic [6:0]       active_tens, active_ones;
    logic [6:0]       pend_tens, pend_ones;
    logic             pend_valid;
    logic             ack_q;
    logic             boundary;

    // Next state; boundary marks the edge that enters TENS
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        boundary  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            div_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = TENS;
                    div_nxt   = '0;
                    boundary  = 1'b1;
                end
                TENS: begin
                    if (div == DIV_LAST) begin
                        state_nxt = ONES;
                        div_nxt   = '0;
                    end else begin
                        div_nxt = div + 1'b1;
                    end
                end
                ONES: begin
                    if (div == DIV_LAST) begin
                        state_nxt = TENS;
                        div_nxt   = '0;
                        boundary  = 1'b1;
                    end else begin
                        div_nxt = div + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    div_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div         <= '0;
            active_tens <= '0;
            active_ones <= '0;
            pend_tens   <= '0;
            pend_ones   <= '0;
            pend_valid  <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            div   <= div_nxt;
            ack_q <= 1'b0;
            if (boundary) begin
                // A load coinciding with the boundary bypasses the pending buffer
                if (load) begin
                    active_tens <= seg_tens_in;
                    active_ones <= seg_ones_in;
                end else if (pend_valid) begin
                    active_tens <= pend_tens;
                    active_ones <= pend_ones;
                end
                pend_valid <= 1'b0;
                ack_q      <= load | pend_valid;
            end else if (load) begin
                pend_tens  <= seg_tens_in;
                pend_ones  <= seg_ones_in;
                pend_valid <= 1'b1;
            end
        end
    end

    logic       in_guard;
    logic       tens_suppress;
    logic [1:0] dig_l;
    logic [6:0] seg_l;

    assign in_guard      = int'(div) < BLANK_CYCLES;
    assign tens_suppress = (BLANK_LEADING_ZERO != 0) && (active_tens == ZERO_GLYPH);

    always_comb begin
        dig_l = 2'b00;
        seg_l = 7'b0000000;
        case (state)
            TENS: begin
                if (!in_guard && !tens_suppress) begin
                    dig_l = 2'b10;
                    seg_l = active_tens;
                end
            end
            ONES: begin
                if (!in_guard) begin
                    dig_l = 2'b01;
                    seg_l = active_ones;
                end
            end
            default: begin
                dig_l = 2'b00;
                seg_l = 7'b0000000;
            end
        endcase
    end

    assign seg_out     = (SEG_ACTIVE_LOW != 0) ? ~seg_l : seg_l;
    assign dig_sel     = (SEG_ACTIVE_LOW != 0) ? ~dig_l : dig_l;
    assign frame_start = (state == TENS) && (div == '0);
    assign update_ack  = ack_q;

endmodule
